alu_control: RTL and testbench

ALU operation decoder between the main control unit and the ALU of the RISC datapath. It combines the 2-bit ALUOp class from main control with the 4-bit instruction function field. It produces a 3-bit ALU operation select, registered on the clock, plus an illegal-function flag. The ALU consumes ALUOp_out in the execute stage.

---
 rtl/alu_control.sv | 68 ++++++
 tb/tb_alu_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// ALU operation decoder with registered outputs.
//
// Combines the 2-bit operation class from main control with the 4-bit
// R-type function field. Produces a 3-bit ALU select and an
// illegal-function flag. Both outputs are captured on the rising clock
// edge when en=1, so there is no combinational path from inputs to outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (outputs -> ADD / 0)
//   en         update enable; 0 holds outputs (pipeline stall)
//   func       instruction function field (R-type)
//   ALUOp      operation class: 00 ld/st, 01 branch, 10 R-type, 11 imm logical
//   ALUOp_out  registered ALU select (000 ADD .. 111 SRL)
//   illegal    registered flag: R-type func code not supported
module alu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] func,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUOp_out,
    output logic       illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b011;

    logic [2:0] next_op;
    logic       next_ill;

    // Full case with an ADD default so an unknown class never holds state.
    always_comb begin
        next_op  = OP_ADD;
        next_ill = 1'b0;
        case (ALUOp)
            2'b00: next_op = OP_ADD;
            2'b01: next_op = OP_SUB;
            2'b10: begin
                // func 0..7 map directly onto the select encoding;
                // func 8..15 are unsupported and flagged.
                if (func[3]) begin
                    next_op  = OP_ADD;
                    next_ill = 1'b1;
                end else begin
                    next_op  = func[2:0];
                end
            end
            2'b11: next_op = OP_OR;
            default: begin
                next_op  = OP_ADD;
                next_ill = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUOp_out <= OP_ADD;
            illegal   <= 1'b0;
        end else if (en) begin
            ALUOp_out <= next_op;
            illegal   <= next_ill;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed scenarios plus a randomized
// run, all compared against a behavioural reference model.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] func;
    logic [1:0] ALUOp;
    logic [2:0] ALUOp_out;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    // Model of the registered outputs.
    logic [2:0] m_op;
    logic       m_ill;

    alu_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .func     (func),
        .ALUOp    (ALUOp),
        .ALUOp_out(ALUOp_out),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Reference decode: returns {illegal, select}.
    function automatic logic [3:0] ref_dec(input logic [1:0] cls, input logic [3:0] f);
        int sel;
        if (cls == 2'd2) begin
            if (f < 8) return {1'b0, f[2:0]};
            return 4'b1000;
        end
        sel = (cls == 2'd0) ? 0 : (cls == 2'd1) ? 1 : 3;
        return {1'b0, sel[2:0]};
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at it.
    task automatic tick();
        logic [3:0] d;
        d = ref_dec(ALUOp, func);
        if (!rst_n) begin
            m_op = 3'b000; m_ill = 1'b0;
        end else if (en) begin
            m_op = d[2:0]; m_ill = d[3];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; func = 4'd2; ALUOp = 2'b10;
        m_op = 3'b000; m_ill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ALUOp_out !== 3'b000 || illegal !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: got %b/%b want 000/0", ALUOp_out, illegal);
            end
        end
        rst_n = 1'b1;
        ALUOp = 2'b11;
        tick();
        tests++;
        if (ALUOp_out !== 3'b011 || illegal !== m_ill) begin
            fails++;
            $display("FAIL reset_pre_or: got %b/%b want 011/0", ALUOp_out, illegal);
        end
        // Assert reset between edges; must take effect without a clock.
        #2 rst_n = 1'b0;
        #1;
        m_op = 3'b000; m_ill = 1'b0;
        tests++;
        if (ALUOp_out !== 3'b000 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got %b/%b want 000/0", ALUOp_out, illegal);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        logic [1:0] cls [3];
        logic [2:0] want [3];
        cls = '{2'b00, 2'b01, 2'b11};
        want = '{3'b000, 3'b001, 3'b011};
        en = 1'b1; func = 4'd2;
        for (int i = 0; i < 3; i++) begin
            ALUOp = cls[i];
            tick();
            tests++;
            if (ALUOp_out !== want[i] || illegal !== 1'b0 || ALUOp_out !== m_op) begin
                fails++;
                $display("FAIL fixed_class%0d: got %b/%b want %b/0", cls[i], ALUOp_out, illegal, want[i]);
            end
        end
    endtask

    task automatic test_rtype();
        en = 1'b1; ALUOp = 2'b10;
        for (int f = 0; f < 8; f++) begin
            func = f[3:0];
            tick();
            tests++;
            if (ALUOp_out !== f[2:0] || illegal !== 1'b0) begin
                fails++;
                $display("FAIL rtype_func%0d: got %b/%b want %b/0", f, ALUOp_out, illegal, f[2:0]);
            end
        end
    endtask

    task automatic test_illegal();
        en = 1'b1; ALUOp = 2'b10;
        for (int f = 8; f < 16; f++) begin
            func = f[3:0];
            tick();
            tests++;
            if (ALUOp_out !== 3'b000 || illegal !== 1'b1) begin
                fails++;
                $display("FAIL illegal_func%0d: got %b/%b want 000/1", f, ALUOp_out, illegal);
            end
        end
        func = 4'd1;
        tick();
        tests++;
        if (ALUOp_out !== 3'b001 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_recover: got %b/%b want 001/0", ALUOp_out, illegal);
        end
    endtask

    task automatic test_stall();
        en = 1'b1; ALUOp = 2'b10; func = 4'd4;
        tick();
        tests++;
        if (ALUOp_out !== 3'b100 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL stall_capture: got %b/%b want 100/0", ALUOp_out, illegal);
        end
        en = 1'b0; ALUOp = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ALUOp_out !== 3'b100 || illegal !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: got %b/%b want 100/0", i, ALUOp_out, illegal);
            end
        end
        en = 1'b1;
        tick();
        tests++;
        if (ALUOp_out !== 3'b001 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: got %b/%b want 001/0", ALUOp_out, illegal);
        end
    endtask

    task automatic test_latency();
        en = 1'b1; ALUOp = 2'b10; func = 4'd7;
        tick();
        // Mid-cycle change must not reach the outputs before the next edge.
        #2 func = 4'd12; ALUOp = 2'b10;
        #2;
        tests++;
        if (ALUOp_out !== 3'b111 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL latency_midcycle: got %b/%b want 111/0", ALUOp_out, illegal);
        end
        tick();
        tests++;
        if (ALUOp_out !== 3'b000 || illegal !== 1'b1) begin
            fails++;
            $display("FAIL latency_edge: got %b/%b want 000/1", ALUOp_out, illegal);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            func  = 4'($urandom_range(0, 15));
            ALUOp = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 29) != 0);
            tick();
            tests++;
            if (ALUOp_out !== m_op || illegal !== m_ill) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random%0d: got %b/%b want %b/%b", i, ALUOp_out, illegal, m_op, m_ill);
                bad++;
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rtype();
        test_illegal();
        test_stall();
        test_latency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
